// File: rtl/wb_irq_ctrl_pkg.sv
// Shared definitions for the Wishbone interrupt controller: register offsets
// and STATUS register field positions.
package wb_irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IRQ_PEND = 2'b00,
        IRQ_EN   = 2'b01,
        IRQ_MODE = 2'b10,
        IRQ_STAT = 2'b11
    } irq_reg_e;

    localparam int STAT_VALID_BIT = 31;
    localparam int STAT_ID_LSB    = 0;
    localparam int STAT_ID_W      = 3;
    localparam int STAT_ACT_LSB   = 8;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous interrupt source, followed by a
// previous-value flop that yields a single-cycle rising-edge pulse.
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_src,
    output logic o_sync,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_src;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_edge = r_sync & ~r_prev;

endmodule

// File: rtl/wb_irq_ctrl.sv
// Wishbone-slave interrupt controller: per-source edge/level capture into a
// pending register, enable masking, registered CPU irq and lowest-ID status.
module wb_irq_ctrl
    import wb_irq_ctrl_pkg::*;
#(
    parameter int               n_src          = 8,
    parameter int               wb_dat_width   = 32,
    parameter int               wb_adr_width   = 32,
    parameter logic [n_src-1:0] en_reset_val   = '0,
    parameter logic [n_src-1:0] mode_reset_val = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [wb_adr_width-1:0] wb_adr_i,
    input  logic [wb_dat_width-1:0] wb_dat_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    output logic                    wb_ack_o,
    output logic [wb_dat_width-1:0] wb_dat_o,
    input  logic [n_src-1:0]        irq_src_i,
    output logic                    irq_o
);

    logic [n_src-1:0]        w_sync;
    logic [n_src-1:0]        w_edge;
    logic [n_src-1:0]        w_active;
    logic [n_src-1:0]        w_w1c;
    logic [n_src-1:0]        w_pending_next;
    logic [n_src-1:0]        r_pending;
    logic [n_src-1:0]        r_en;
    logic [n_src-1:0]        r_mode;
    logic                    r_ack;
    logic                    r_irq;
    logic [wb_dat_width-1:0] r_dat;
    logic [wb_dat_width-1:0] w_rdata;
    logic [STAT_ID_W-1:0]    w_id;
    logic                    w_accept;
    logic                    w_wr;
    irq_reg_e                w_reg;
    logic                    w_unused;

    generate
        for (genvar gi = 0; gi < n_src; gi++) begin : g_src
            irq_sync_edge u_sync (
                .clk    (clk),
                .rst    (rst),
                .i_src  (irq_src_i[gi]),
                .o_sync (w_sync[gi]),
                .o_edge (w_edge[gi])
            );
        end
    endgenerate

    // The internal ack flop blocks acceptance, so each access takes two clocks.
    assign w_accept = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_wr     = w_accept & wb_we_i;
    assign w_reg    = irq_reg_e'(wb_adr_i[3:2]);
    assign w_w1c    = (w_wr && (w_reg == IRQ_PEND)) ? wb_dat_i[n_src-1:0] : '0;

    // Level bits track the synchronized input; edge bits set-dominate over W1C.
    assign w_pending_next = (r_mode & w_sync)
                          | (~r_mode & ((r_pending & ~w_w1c) | w_edge));

    assign w_active = r_pending & r_en;

    always_comb begin
        w_id = '0;
        for (int i = n_src - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_id = STAT_ID_W'(i);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            IRQ_PEND: w_rdata[n_src-1:0] = r_pending;
            IRQ_EN:   w_rdata[n_src-1:0] = r_en;
            IRQ_MODE: w_rdata[n_src-1:0] = r_mode;
            IRQ_STAT: begin
                w_rdata[STAT_VALID_BIT]              = |w_active;
                w_rdata[STAT_ID_LSB +: STAT_ID_W]    = w_id;
                w_rdata[STAT_ACT_LSB +: n_src]       = w_active;
            end
            default:  w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_en      <= en_reset_val;
            r_mode    <= mode_reset_val;
            r_ack     <= 1'b0;
            r_irq     <= 1'b0;
            r_dat     <= '0;
        end else begin
            r_pending <= w_pending_next;
            r_ack     <= w_accept;
            r_irq     <= |w_active;
            if (w_accept) begin
                r_dat <= w_rdata;
            end
            if (w_wr && (w_reg == IRQ_EN)) begin
                r_en <= wb_dat_i[n_src-1:0];
            end
            if (w_wr && (w_reg == IRQ_MODE)) begin
                r_mode <= wb_dat_i[n_src-1:0];
            end
        end
    end

    // A dropped strobe or cycle hides the ack that is already in flight.
    assign wb_ack_o = r_ack & wb_stb_i & wb_cyc_i;
    assign wb_dat_o = r_dat;
    assign irq_o    = r_irq;

    assign w_unused = ^{wb_adr_i[wb_adr_width-1:4], wb_adr_i[1:0],
                        wb_dat_i[wb_dat_width-1:n_src]};

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Self-checking bench for wb_irq_ctrl: directed table, hand-written corner
// sequences, and random bus/source traffic against a behavioural model.
module tb_wb_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic [7:0]  irq_src_i;
    logic        irq_o;

    wb_irq_ctrl #(
        .n_src        (8),
        .wb_dat_width (32),
        .wb_adr_width (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_we_i   (wb_we_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_ack_o  (wb_ack_o),
        .wb_dat_o  (wb_dat_o),
        .irq_src_i (irq_src_i),
        .irq_o     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  m_pend, m_en, m_mode;
    logic        m_ack, m_irq, m_rd;
    logic [31:0] m_dat;
    logic [7:0]  hist[$];   // hist[k] = source value sampled k+1 clocks ago

    typedef struct {
        logic        we;
        logic [1:0]  r;
        logic [31:0] d;
        logic [7:0]  src;
        int          settle;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tv[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 8'h00; m_en = 8'h00; m_mode = 8'h00;
        m_ack = 1'b0; m_irq = 1'b0; m_rd = 1'b0; m_dat = 32'h0;
        hist = '{8'h00, 8'h00, 8'h00};
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] r);
        logic [7:0]  act;
        logic [7:0]  lsb;
        logic [2:0]  id;
        act = m_pend & m_en;
        lsb = act & (~act + 8'd1);
        id  = (act == 8'h00) ? 3'd0 : 3'($clog2(lsb));
        case (r)
            2'd0:    return {24'h0, m_pend};
            2'd1:    return {24'h0, m_en};
            2'd2:    return {24'h0, m_mode};
            default: return {(act != 8'h00), 15'h0, act, 5'h0, id};
        endcase
    endfunction

    task automatic check_outputs();
        logic exp_ack;
        exp_ack = m_ack & wb_stb_i & wb_cyc_i;
        chk("irq_o", {31'h0, irq_o}, {31'h0, m_irq});
        chk("wb_ack_o", {31'h0, wb_ack_o}, {31'h0, exp_ack});
        if (exp_ack && m_rd) chk("wb_dat_o", wb_dat_o, m_dat);
    endtask

    // Advance one clock: model computes next state from pre-edge values and
    // the currently driven inputs, then outputs are compared on the negedge.
    task automatic cycle();
        logic [7:0] lvl, eh, w1c, nxt;
        logic       acc;
        logic [1:0] r;
        if (!rst) begin
            model_reset();
        end else begin
            lvl = hist[1];
            eh  = hist[1] & ~hist[2];
            acc = wb_stb_i & wb_cyc_i & ~m_ack;
            r   = wb_adr_i[3:2];
            w1c = (acc && wb_we_i && r == 2'd0) ? wb_dat_i[7:0] : 8'h00;
            nxt = (m_mode & lvl) | (~m_mode & ((m_pend & ~w1c) | eh));
            m_irq = |(m_pend & m_en);
            if (acc) begin
                m_rd = ~wb_we_i;
                if (!wb_we_i) m_dat = m_read(r);
                if (wb_we_i && r == 2'd1) m_en = wb_dat_i[7:0];
                if (wb_we_i && r == 2'd2) m_mode = wb_dat_i[7:0];
            end
            m_pend = nxt;
            m_ack  = acc;
            hist.push_front(irq_src_i);
            void'(hist.pop_back());
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic bus(input logic we, input logic [1:0] r, input logic [31:0] d,
                       output logic [31:0] rd);
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
        wb_adr_i = {28'h0, r, 2'b00}; wb_dat_i = d;
        cycle();
        chk("ack_2nd_clk", {31'h0, wb_ack_o}, 32'h1);
        rd = wb_dat_o;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        irq_src_i = 8'h00;
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        rst = 1'b0; wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; irq_src_i = 8'h00;
        model_reset();

        //        we    reg   wdata         src    settle exp_rd        irq
        tv[0]  = '{1'b0, 2'd0, 32'h0,        8'h00, 0, 32'h0000_0000, 1'b0};
        tv[1]  = '{1'b0, 2'd1, 32'h0,        8'h00, 0, 32'h0000_0000, 1'b0};
        tv[2]  = '{1'b0, 2'd2, 32'h0,        8'h00, 0, 32'h0000_0000, 1'b0};
        tv[3]  = '{1'b0, 2'd3, 32'h0,        8'h00, 0, 32'h0000_0000, 1'b0};
        tv[4]  = '{1'b1, 2'd1, 32'h01,       8'h00, 0, 32'h0,         1'b0};
        tv[5]  = '{1'b0, 2'd0, 32'h0,        8'h01, 3, 32'h0000_0001, 1'b1};
        tv[6]  = '{1'b0, 2'd3, 32'h0,        8'h01, 0, 32'h8000_0100, 1'b1};
        tv[7]  = '{1'b1, 2'd0, 32'h01,       8'h01, 0, 32'h0,         1'b0};
        tv[8]  = '{1'b0, 2'd0, 32'h0,        8'h01, 0, 32'h0000_0000, 1'b0};
        tv[9]  = '{1'b1, 2'd1, 32'h24,       8'h01, 0, 32'h0,         1'b0};
        tv[10] = '{1'b0, 2'd3, 32'h0,        8'h25, 3, 32'h8000_2402, 1'b1};
        tv[11] = '{1'b1, 2'd0, 32'h04,       8'h25, 0, 32'h0,         1'b1};
        tv[12] = '{1'b0, 2'd3, 32'h0,        8'h25, 0, 32'h8000_2005, 1'b1};
        tv[13] = '{1'b1, 2'd1, 32'h00,       8'h25, 0, 32'h0,         1'b0};
        tv[14] = '{1'b0, 2'd0, 32'h0,        8'h25, 0, 32'h0000_0020, 1'b0};
        tv[15] = '{1'b0, 2'd1, 32'h0,        8'h25, 0, 32'h0000_0000, 1'b0};
        tv[16] = '{1'b1, 2'd1, 32'h20,       8'h25, 0, 32'h0,         1'b1};
        tv[17] = '{1'b0, 2'd3, 32'h0,        8'h25, 0, 32'h8000_2005, 1'b1};

        @(negedge clk);
        do_reset();
        chk("reset_irq", {31'h0, irq_o}, 32'h0);

        for (int i = 0; i < 18; i++) begin
            irq_src_i = tv[i].src;
            repeat (tv[i].settle) cycle();
            bus(tv[i].we, tv[i].r, tv[i].d, rd);
            if (!tv[i].we) chk($sformatf("tbl%0d_rd", i), rd, tv[i].exp_rd);
            chk($sformatf("tbl%0d_irq", i), {31'h0, irq_o}, {31'h0, tv[i].exp_irq});
        end

        // One-clock pulse, W1C, then an edge colliding with a W1C
        do_reset();
        bus(1'b1, 2'd1, 32'h01, rd);
        irq_src_i = 8'h01; cycle();
        irq_src_i = 8'h00; cycle(); cycle();
        bus(1'b0, 2'd0, 32'h0, rd);
        chk("pulse_pend", rd, 32'h1);
        chk("pulse_irq", {31'h0, irq_o}, 32'h1);
        bus(1'b1, 2'd0, 32'h01, rd);
        chk("w1c_irq", {31'h0, irq_o}, 32'h0);
        irq_src_i = 8'h01; cycle(); cycle();
        bus(1'b1, 2'd0, 32'h01, rd);
        bus(1'b0, 2'd0, 32'h0, rd);
        chk("collide_pend", rd, 32'h1);
        irq_src_i = 8'h00;

        // Level mode: W1C ignored, pending follows the source with 3 clk lag
        do_reset();
        bus(1'b1, 2'd2, 32'h08, rd);
        bus(1'b1, 2'd1, 32'h08, rd);
        irq_src_i = 8'h08;
        repeat (3) cycle();
        bus(1'b0, 2'd0, 32'h0, rd);
        chk("lvl_pend", rd, 32'h08);
        chk("lvl_irq", {31'h0, irq_o}, 32'h1);
        bus(1'b1, 2'd0, 32'h08, rd);
        bus(1'b0, 2'd0, 32'h0, rd);
        chk("lvl_w1c_ignored", rd, 32'h08);
        irq_src_i = 8'h00;
        repeat (3) cycle();
        chk("lvl_irq_hold", {31'h0, irq_o}, 32'h1);
        cycle();
        chk("lvl_irq_fall", {31'h0, irq_o}, 32'h0);

        // Asynchronous reset in the middle of a read
        do_reset();
        bus(1'b1, 2'd1, 32'h01, rd);
        irq_src_i = 8'h01;
        repeat (4) cycle();
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
        cycle();
        chk("pre_rst_ack", {31'h0, wb_ack_o}, 32'h1);
        chk("pre_rst_dat", wb_dat_o, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("arst_ack", {31'h0, wb_ack_o}, 32'h0);
        chk("arst_irq", {31'h0, irq_o}, 32'h0);
        chk("arst_dat", wb_dat_o, 32'h0);
        model_reset();
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; irq_src_i = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < 4; r++) begin
            bus(1'b0, 2'(r), 32'h0, rd);
            chk($sformatf("post_rst_reg%0d", r), rd, 32'h0);
        end

        // Random traffic, including aborted cycles and mixed edge/level modes
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            wb_stb_i = ($urandom_range(0, 9) < 7);
            wb_cyc_i = ($urandom_range(0, 9) < 8);
            wb_we_i  = $urandom_range(0, 1) == 1;
            wb_adr_i = $urandom;
            wb_dat_i = $urandom;
            if ($urandom_range(0, 3) == 0) irq_src_i = irq_src_i ^ 8'($urandom);
            cycle();
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
